fetch_queue_unit: RTL and testbench

- Parametrised successor of the single-entry fetch stage.
- Issues in-order instruction requests on the ibus with a full addr_ok/data_ok handshake and supports multiple outstanding requests.
- Buffers returned instructions, with their PCs, in a DEPTH-entry queue that feeds decode through a valid/ready interface.
- Handles redirects from decode/execute by flushing the queue and discarding responses still in flight.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_queue_buf.sv | 122 ++++++++++++
 rtl/fetch_queue_unit.sv | 167 ++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the fetch queue unit and its buffer.
//   ibus_req_t  - request channel to the instruction bus (valid, addr)
//   ibus_resp_t - response channel from the instruction bus (addr_ok, data_ok, data)
//   fq_entry_t  - one fetch queue slot (pc, instr, filled, adel)
//   DEFAULT_RESET_PC - fetch address used after reset unless overridden
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'hbfc0_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
    logic        adel;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_buf.sv
// fetch_queue_buf: DEPTH-entry in-order fetch queue storage.
// Entries are allocated at the tail when a fetch is issued, completed in
// allocation order through the fill pointer, and popped from the head.
// Ports:
//   clk, resetn  - clock and synchronous active-low reset
//   flush        - drop every entry and rewind all pointers (wins over all else)
//   alloc        - write alloc_entry at the tail
//   alloc_entry  - entry to allocate (filled=1 for address-error entries)
//   fill         - complete the oldest unfilled entry with fill_data
//   fill_data    - instruction word returned by the bus
//   pop          - remove the head entry
//   head_entry   - current head slot, read straight from storage
//   pending      - number of allocated entries still waiting for bus data
//   full         - all DEPTH slots are allocated
module fetch_queue_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           flush,
  input  logic           alloc,
  input  fq_entry_t      alloc_entry,
  input  logic           fill,
  input  logic [31:0]    fill_data,
  input  logic           pop,
  output fq_entry_t      head_entry,
  output logic [PTR_W:0] pending,
  output logic           full
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  fq_entry_t        entries_q [DEPTH];
  fq_entry_t        entries_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             alloc_pend;

  // Next-state for storage and pointers. Alloc, fill and pop never touch the
  // same slot in one cycle: alloc writes an unallocated slot, fill writes an
  // unfilled one and pop removes a filled one. Popping clears the filled bit
  // so a stale slot cannot look valid once the head wraps back onto it.
  always_comb begin
    entries_d  = entries_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    count_d    = count_q;
    pending_d  = pending_q;
    alloc_pend = alloc & ~alloc_entry.filled;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i] = '0;
      end
      head_d    = '0;
      tail_d    = '0;
      fill_d    = '0;
      count_d   = '0;
      pending_d = '0;
    end else begin
      if (alloc) begin
        entries_d[tail_q] = alloc_entry;
        tail_d            = tail_q + PTR_ONE;
      end
      if (fill) begin
        entries_d[fill_q].instr  = fill_data;
        entries_d[fill_q].filled = 1'b1;
        fill_d                   = fill_q + PTR_ONE;
      end
      if (pop) begin
        entries_d[head_q].filled = 1'b0;
        head_d                   = head_q + PTR_ONE;
      end
      case ({alloc, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      case ({alloc_pend, fill})
        2'b10:   pending_d = pending_q + CNT_ONE;
        2'b01:   pending_d = pending_q - CNT_ONE;
        default: pending_d = pending_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q    <= '0;
      tail_q    <= '0;
      fill_q    <= '0;
      count_q   <= '0;
      pending_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      head_q    <= head_d;
      tail_q    <= tail_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  assign head_entry = entries_q[head_q];
  assign pending    = pending_q;
  assign full       = (count_q == CNT_FULL);

endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: pipelined instruction fetch with a DEPTH-entry queue.
// Issues in-order requests on the ibus (addr_ok/data_ok handshake, several
// requests in flight), buffers the returned words with their PCs and hands
// them to decode through valid/ready. A redirect flushes the queue; responses
// for flushed requests are counted in discard_cnt and dropped on arrival.
// Optional feature macro: FETCH_QUEUE_PERF_EN (accept/discard counters).
// Ports:
//   clk, resetn        - clock and synchronous active-low reset
//   redirect_valid     - flush and restart fetch at redirect_pc
//   redirect_pc        - new fetch address
//   ireq               - request to the instruction bus
//   iresp              - addr_ok / data_ok / data from the instruction bus
//   out_valid          - head entry is complete
//   out_ready          - decode takes the head this cycle
//   out_pc, out_instr  - PC and instruction of the head entry
//   out_adel           - head entry is a misaligned-fetch address error
//   perf_fetch_cnt     - accepted requests (0 without FETCH_QUEUE_PERF_EN)
//   perf_discard_cnt   - dropped responses (0 without FETCH_QUEUE_PERF_EN)
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_adel,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_discard_cnt
);

  localparam int DISC_W = $clog2(2 * DEPTH + 1);
  localparam logic [DISC_W-1:0] DISC_ONE = DISC_W'(1);

  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic              halted_q, halted_d;
  logic [DISC_W-1:0] discard_q, discard_d;

  logic              issue_ok;
  logic              misaligned;
  logic              accept;
  logic              adel_alloc;
  logic              discard_hit;
  logic              q_alloc;
  fq_entry_t         q_alloc_entry;
  logic              q_fill;
  logic              q_pop;
  fq_entry_t         q_head;
  logic [PTR_W:0]    q_pending;
  logic              q_full;

  // Issue and queue control. A misaligned fetch_pc never reaches the bus:
  // it becomes an already-complete address-error entry and halts issue.
  // A response is dropped when older discards are owed, or when it lands in
  // a redirect cycle, since then it belongs to an entry being flushed.
  always_comb begin
    issue_ok    = resetn & ~redirect_valid & ~halted_q & ~q_full;
    misaligned  = (fetch_pc_q[1:0] != 2'b00);
    ireq.valid  = issue_ok & ~misaligned;
    ireq.addr   = fetch_pc_q;
    accept      = ireq.valid & iresp.addr_ok;
    adel_alloc  = issue_ok & misaligned;
    discard_hit = iresp.data_ok & ((discard_q != '0) | redirect_valid);
    q_fill      = iresp.data_ok & ~discard_hit;
    q_pop       = q_head.filled & out_ready & ~redirect_valid;
    q_alloc     = accept | adel_alloc;
    q_alloc_entry.pc     = fetch_pc_q;
    q_alloc_entry.instr  = '0;
    q_alloc_entry.filled = adel_alloc;
    q_alloc_entry.adel   = adel_alloc;
  end

  // Fetch PC, halt flag and discard count. On a redirect every entry still
  // waiting for data is turned into an owed discard; the optional decrement
  // covers a response consumed as a discard in the same cycle.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    halted_d   = halted_q;
    discard_d  = discard_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      halted_d   = 1'b0;
      discard_d  = discard_q + DISC_W'(q_pending);
    end else if (accept) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end else if (adel_alloc) begin
      halted_d = 1'b1;
    end
    if (discard_hit) begin
      discard_d = discard_d - DISC_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc_q <= RESET_PC;
      halted_q   <= 1'b0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      halted_q   <= halted_d;
      discard_q  <= discard_d;
    end
  end

  fetch_queue_buf #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (redirect_valid),
    .alloc       (q_alloc),
    .alloc_entry (q_alloc_entry),
    .fill        (q_fill),
    .fill_data   (iresp.data),
    .pop         (q_pop),
    .head_entry  (q_head),
    .pending     (q_pending),
    .full        (q_full)
  );

  // Head fields are masked while the head is incomplete so decode never sees
  // stale data from a previously popped slot.
  always_comb begin
    out_valid = q_head.filled;
    out_pc    = q_head.filled ? q_head.pc : '0;
    out_instr = q_head.filled ? q_head.instr : '0;
    out_adel  = q_head.filled & q_head.adel;
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_discard_q, perf_discard_d;

  // Free-running wrapping event counters, cleared only by reset.
  always_comb begin
    perf_fetch_d   = perf_fetch_q + (accept ? 32'd1 : 32'd0);
    perf_discard_d = perf_discard_q + (discard_hit ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_fetch_q   <= '0;
      perf_discard_q <= '0;
    end else begin
      perf_fetch_q   <= perf_fetch_d;
      perf_discard_q <= perf_discard_d;
    end
  end

  assign perf_fetch_cnt   = perf_fetch_q;
  assign perf_discard_cnt = perf_discard_q;
`else
  assign perf_fetch_cnt   = '0;
  assign perf_discard_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: self-checking bench for fetch_queue_unit.
// A queue-based reference model and a simple in-order bus model run beside
// the DUT; directed scenarios are followed by a randomized stretch.
module tb_fetch_queue_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

  logic        clk;
  logic        resetn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_adel;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_discard_cnt;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          filled;
    bit          adel;
  } model_entry_t;

  model_entry_t m_q[$];
  logic [31:0]  bus_q[$];
  logic [31:0]  m_pc;
  bit           m_halted;
  int           m_discard;
  logic [31:0]  m_perf_fetch;
  logic [31:0]  m_perf_discard;

  int vectors;
  int miscompares;

  fetch_queue_unit #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .ireq            (ireq),
    .iresp           (iresp),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr),
    .out_adel        (out_adel),
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_discard_cnt(perf_discard_cnt)
  );

  // Free-running clock; inputs change on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction word the bus model returns for a given address.
  function automatic logic [31:0] busData(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h3c5a_96e1;
  endfunction

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input bit exp_req, input bit exp_vld);
    logic [31:0] exp_pf;
    logic [31:0] exp_pd;
`ifdef FETCH_QUEUE_PERF_EN
    exp_pf = m_perf_fetch;
    exp_pd = m_perf_discard;
`else
    exp_pf = 32'd0;
    exp_pd = 32'd0;
`endif
    checkOne("ireq.valid", 32'(ireq.valid), 32'(exp_req));
    if (exp_req) checkOne("ireq.addr", ireq.addr, m_pc);
    checkOne("out_valid", 32'(out_valid), 32'(exp_vld));
    if (exp_vld) begin
      checkOne("out_pc", out_pc, m_q[0].pc);
      checkOne("out_instr", out_instr, m_q[0].instr);
      checkOne("out_adel", 32'(out_adel), 32'(m_q[0].adel));
    end
    checkOne("perf_fetch_cnt", perf_fetch_cnt, exp_pf);
    checkOne("perf_discard_cnt", perf_discard_cnt, exp_pd);
  endtask

  task automatic doReset();
    resetn         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    out_ready      = 1'b0;
    iresp          = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOne("reset ireq.valid", 32'(ireq.valid), 32'd0);
    checkOne("reset out_valid", 32'(out_valid), 32'd0);
    checkOne("reset out_pc", out_pc, 32'd0);
    checkOne("reset out_instr", out_instr, 32'd0);
    checkOne("reset out_adel", 32'(out_adel), 32'd0);
    checkOne("reset perf_fetch_cnt", perf_fetch_cnt, 32'd0);
    checkOne("reset perf_discard_cnt", perf_discard_cnt, 32'd0);
    m_q.delete();
    bus_q.delete();
    m_pc           = RESET_PC;
    m_halted       = 1'b0;
    m_discard      = 0;
    m_perf_fetch   = 32'd0;
    m_perf_discard = 32'd0;
    resetn         = 1'b1;
    @(negedge clk);
  endtask

  // One cycle: drive inputs, check outputs against the model, then advance
  // the model by the events of this cycle.
  task automatic applyStimulus(input bit a_ok, input bit d_req, input bit rdy,
                               input bit redir, input logic [31:0] rpc);
    bit          dv;
    bit          exp_req;
    bit          exp_adel;
    bit          exp_vld;
    bit          pop;
    int          unfilled;
    logic [31:0] dval;
    dv   = d_req && (bus_q.size() > 0);
    dval = dv ? busData(bus_q[0]) : $urandom();
    iresp.addr_ok  = a_ok;
    iresp.data_ok  = dv;
    iresp.data     = dval;
    out_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
    exp_req  = !redir && !m_halted && (m_q.size() < DEPTH) && (m_pc[1:0] == 2'b00);
    exp_adel = !redir && !m_halted && (m_q.size() < DEPTH) && (m_pc[1:0] != 2'b00);
    exp_vld  = (m_q.size() > 0) && m_q[0].filled;
    checkOutput(exp_req, exp_vld);
    pop = exp_vld && rdy && !redir;
    if (dv) begin
      void'(bus_q.pop_front());
      if (m_discard > 0) begin
        m_discard--;
        m_perf_discard++;
      end else begin
        foreach (m_q[i]) begin
          if (!m_q[i].filled) begin
            m_q[i].instr  = dval;
            m_q[i].filled = 1'b1;
            break;
          end
        end
        if (redir) m_perf_discard++;
      end
    end
    if (redir) begin
      unfilled = 0;
      foreach (m_q[i]) if (!m_q[i].filled) unfilled++;
      m_discard += unfilled;
      m_q.delete();
      m_pc     = rpc;
      m_halted = 1'b0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (exp_req && a_ok) begin
        m_q.push_back('{pc: m_pc, instr: 32'd0, filled: 1'b0, adel: 1'b0});
        bus_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
        m_perf_fetch++;
      end else if (exp_adel) begin
        m_q.push_back('{pc: m_pc, instr: 32'd0, filled: 1'b1, adel: 1'b1});
        m_halted = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bit          a;
    bit          d;
    bit          r;
    bit          rd;
    logic [31:0] rpc;
    vectors     = 0;
    miscompares = 0;

    // Streaming: bus always ready, decode always ready.
    doReset();
    repeat (10) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);

    // Full queue with decode stalled, then a single pop reopens one slot.
    doReset();
    repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);

    // Address handshake stalled for three cycles.
    doReset();
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);

    // Redirect with two requests in flight, then a misaligned redirect.
    doReset();
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_1000);
    repeat (8) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0002);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0000);
    repeat (6) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);

    // Redirect coinciding with the only outstanding response.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_2000);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

    // Randomized traffic; redirects only while few responses are owed.
    doReset();
    for (int c = 0; c < 1500; c++) begin
      a   = ($urandom_range(0, 9) < 7);
      d   = ($urandom_range(0, 9) < 6);
      r   = ($urandom_range(0, 9) < 7);
      rd  = ($urandom_range(0, 99) < 4) && (bus_q.size() <= DEPTH);
      rpc = 32'h8000_0000 + 32'($urandom_range(0, 1023)) * 32'd4;
      if ($urandom_range(0, 9) == 0) rpc = rpc | 32'($urandom_range(1, 3));
      applyStimulus(a, d, r, rd, rpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
